spi_slave_regs: RTL and testbench

//  SPI mode-0 slave (responder) that bridges an external SPI master to an 8-bit register bus.
//  It is the far-end counterpart of the MCU SPI master (SPI_CLK/SPI_MOSI/SPI_MISO/SPI_CSNx),

---
 rtl/spi_slave_pkg.sv | 15 +
 rtl/spi_slave_regs_if.sv | 27 ++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_regs.sv | 154 +++++++++++++++
 tb/tb_spi_slave_regs.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and widths for the SPI mode-0 slave register bridge.
package spi_slave_pkg;

   localparam int ADDR_W     = 7;
   localparam int BYTE_W     = 8;
   localparam int CNT_W      = 3;
   localparam int CMD_RW_BIT = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } state_e;

endpackage

// File: rtl/spi_slave_regs_if.sv
// Register bus between the SPI slave (master modport) and the register file (slave modport).
interface spi_slave_regs_if;
   import spi_slave_pkg::*;

   logic [ADDR_W-1:0] reg_addr;
   logic [BYTE_W-1:0] reg_wdata;
   logic              reg_we;
   logic              reg_re;
   logic [BYTE_W-1:0] reg_rdata;

   modport master (
      output reg_addr,
      output reg_wdata,
      output reg_we,
      output reg_re,
      input  reg_rdata
   );

   modport slave (
      input  reg_addr,
      input  reg_wdata,
      input  reg_we,
      input  reg_re,
      output reg_rdata
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin, with single-cycle rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Synchronizer chain plus one flop of history for edge detection
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave bridging an external master to an 8-bit register bus; SCLK is
// oversampled on the system clock. Frame: command byte {rw, addr[6:0]} then data bytes.
module spi_slave_regs
   import spi_slave_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int AUTO_INC    = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             spi_sclk,
   input  logic             spi_csn,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic             spi_miso_oe,
   spi_slave_regs_if.master bus,
   output logic             busy,
   output logic             frame_err
);

   logic sclk_lvl_unused, sclk_rise_s, sclk_fall_s;
   logic csn_lvl_s, csn_rise_unused, csn_fall_s;
   logic mosi_lvl_s, mosi_rise_unused, mosi_fall_unused;

   // csn idles high so reset cannot fake a frame start
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clock(clock), .reset(reset), .async_i(spi_sclk),
      .level_o(sclk_lvl_unused), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
   );
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
      .clock(clock), .reset(reset), .async_i(spi_csn),
      .level_o(csn_lvl_s), .rise_o(csn_rise_unused), .fall_o(csn_fall_s)
   );
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clock(clock), .reset(reset), .async_i(spi_mosi),
      .level_o(mosi_lvl_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
   );

   state_e            state_q;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [BYTE_W-1:0] rx_shift_q, tx_shift_q, tx_next_q, reg_wdata_q;
   logic [ADDR_W-1:0] addr_q, reg_addr_q;
   logic              rw_q, reg_we_q, reg_re_q, busy_q, frame_err_q, miso_oe_q;

   logic [BYTE_W-1:0] rx_byte_d;
   logic [ADDR_W-1:0] addr_inc_d;
   logic [CNT_W-1:0]  bit_cnt_adv_d;

   // Completed byte, next address, and the bit count as if this cycle's rise were taken
   always_comb begin
      rx_byte_d     = {rx_shift_q[BYTE_W-2:0], mosi_lvl_s};
      addr_inc_d    = addr_q + ADDR_W'(AUTO_INC);
      bit_cnt_adv_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, sclk_rise_s};
   end

   // Frame FSM, shift registers, address tracking and register-bus strobes
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= {CNT_W{1'b0}};
         rx_shift_q  <= {BYTE_W{1'b0}};
         tx_shift_q  <= {BYTE_W{1'b0}};
         tx_next_q   <= {BYTE_W{1'b0}};
         reg_wdata_q <= {BYTE_W{1'b0}};
         addr_q      <= {ADDR_W{1'b0}};
         reg_addr_q  <= {ADDR_W{1'b0}};
         rw_q        <= 1'b0;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         miso_oe_q   <= 1'b0;
      end else begin
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         frame_err_q <= 1'b0;
         miso_oe_q   <= ~csn_lvl_s;
         if (reg_re_q) begin
            tx_next_q <= bus.reg_rdata;
         end
         if (csn_lvl_s) begin
            // Deselect aborts everything; a byte finishing on this very cycle still counts as whole
            if (state_q != IDLE) begin
               frame_err_q <= (bit_cnt_adv_d != {CNT_W{1'b0}});
            end
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            bit_cnt_q  <= {CNT_W{1'b0}};
            tx_shift_q <= {BYTE_W{1'b0}};
         end else begin
            case (state_q)
               IDLE: begin
                  if (csn_fall_s) begin
                     state_q    <= CMD;
                     busy_q     <= 1'b1;
                     bit_cnt_q  <= {CNT_W{1'b0}};
                     rx_shift_q <= {BYTE_W{1'b0}};
                     tx_shift_q <= {BYTE_W{1'b0}};
                     tx_next_q  <= {BYTE_W{1'b0}};
                  end
               end
               CMD, DATA: begin
                  if (sclk_rise_s) begin
                     rx_shift_q <= rx_byte_d;
                     bit_cnt_q  <= bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                     if (bit_cnt_q == {CNT_W{1'b1}}) begin
                        if (state_q == CMD) begin
                           state_q <= DATA;
                           rw_q    <= rx_byte_d[CMD_RW_BIT];
                           addr_q  <= rx_byte_d[ADDR_W-1:0];
                           if (rx_byte_d[CMD_RW_BIT]) begin
                              reg_re_q   <= 1'b1;
                              reg_addr_q <= rx_byte_d[ADDR_W-1:0];
                           end
                        end else if (rw_q) begin
                           // Prefetch the following byte so the master never waits
                           addr_q     <= addr_inc_d;
                           reg_addr_q <= addr_inc_d;
                           reg_re_q   <= 1'b1;
                        end else begin
                           reg_we_q    <= 1'b1;
                           reg_addr_q  <= addr_q;
                           reg_wdata_q <= rx_byte_d;
                           addr_q      <= addr_inc_d;
                        end
                     end
                  end
                  if (sclk_fall_s) begin
                     if (bit_cnt_q == {CNT_W{1'b0}}) begin
                        tx_shift_q <= tx_next_q;
                     end else begin
                        tx_shift_q <= {tx_shift_q[BYTE_W-2:0], 1'b0};
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign spi_miso      = tx_shift_q[BYTE_W-1];
   assign spi_miso_oe   = miso_oe_q;
   assign bus.reg_addr  = reg_addr_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign bus.reg_we    = reg_we_q;
   assign bus.reg_re    = reg_re_q;
   assign busy          = busy_q;
   assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: acts as SPI master at SCLK = clock/8 and as register file.
module tb_spi_slave_regs;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       spi_sclk = 1'b0, spi_csn = 1'b1, spi_mosi = 1'b0;
   logic       spi_miso, spi_miso_oe, busy, frame_err;
   logic       ni_miso, ni_oe, ni_busy, ni_fe;
   logic       model_mode = 1'b0;
   logic [7:0] mem [128];
   logic [7:0] exp_mem [128];
   logic [7:0] tx_buf [16];
   logic [7:0] rx_buf [16];
   logic [7:0] we_addr_q[$], we_data_q[$], re_addr_q[$], ni_addr_q[$];
   int         both_cnt = 0, fe_cycles = 0;
   int         n_checks = 0, n_errors = 0;

   spi_slave_regs_if bus ();
   spi_slave_regs_if bus_ni ();

   spi_slave_regs #(.SYNC_STAGES(2), .AUTO_INC(1)) dut (
      .clock(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .bus(bus), .busy(busy), .frame_err(frame_err)
   );

   spi_slave_regs #(.SYNC_STAGES(2), .AUTO_INC(0)) dut_ni (
      .clock(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
      .spi_miso(ni_miso), .spi_miso_oe(ni_oe), .bus(bus_ni), .busy(ni_busy), .frame_err(ni_fe)
   );

   always #5 clk = ~clk;

   always_comb begin
      if (model_mode) bus.reg_rdata = mem[bus.reg_addr];
      else            bus.reg_rdata = {1'b0, bus.reg_addr} + 8'h40;
   end
   assign bus_ni.reg_rdata = 8'h00;

   always @(posedge clk) begin
      if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
   end

   always @(negedge clk) begin
      if (bus.reg_we) begin
         we_addr_q.push_back({1'b0, bus.reg_addr});
         we_data_q.push_back(bus.reg_wdata);
      end
      if (bus.reg_re) re_addr_q.push_back({1'b0, bus.reg_addr});
      if (bus.reg_we && bus.reg_re) both_cnt++;
      if (bus_ni.reg_we) ni_addr_q.push_back({1'b0, bus_ni.reg_addr});
      if (frame_err) fe_cycles++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] q_at(input logic [7:0] q[$], input int i);
      if (i < q.size()) return {24'h0, q[i]};
      else              return 32'hDEAD_BEEF;
   endfunction

   task automatic clear_logs();
      we_addr_q.delete(); we_data_q.delete(); re_addr_q.delete(); ni_addr_q.delete();
      both_cnt = 0; fe_cycles = 0;
   endtask

   task automatic sclk_half();
      repeat (4) @(negedge clk);
   endtask

   task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = tx[7-i];
         sclk_half();
         rx = {rx[6:0], spi_miso};
         spi_sclk = 1'b1;
         sclk_half();
         spi_sclk = 1'b0;
      end
   endtask

   task automatic csn_high();
      sclk_half();
      spi_csn = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic run_frame(input int n, input int pre);
      logic [7:0] r;
      spi_csn = 1'b0;
      repeat (pre) begin sclk_half(); sclk_half(); end
      check_eq("miso_oe_on", {31'h0, spi_miso_oe}, 32'h1);
      for (int b = 0; b < n; b++) begin
         xfer_bits(tx_buf[b], 8, r);
         rx_buf[b] = r;
      end
      csn_high();
      check_eq("miso_oe_off", {31'h0, spi_miso_oe}, 32'h0);
   endtask

   initial begin
      logic [7:0] r;
      logic [6:0] a;
      int         pre;
      for (int i = 0; i < 128; i++) begin mem[i] = 8'h00; exp_mem[i] = 8'h00; end

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_busy", {31'h0, busy}, 32'h0);
      check_eq("rst_miso", {31'h0, spi_miso}, 32'h0);
      check_eq("rst_oe", {31'h0, spi_miso_oe}, 32'h0);
      check_eq("rst_addr", {25'h0, bus.reg_addr}, 32'h0);
      check_eq("rst_strobes", {29'h0, bus.reg_we, bus.reg_re, frame_err}, 32'h0);
      check_eq("rst_ni", {28'h0, ni_miso, ni_oe, ni_busy, ni_fe}, 32'h0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("idle_busy", {31'h0, busy}, 32'h0);

      // 1: write burst
      clear_logs();
      tx_buf[0] = 8'h05; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
      run_frame(4, 1);
      check_eq("t1_we_cnt", we_addr_q.size(), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check_eq("t1_we_addr", q_at(we_addr_q, i), 32'h05 + i);
         check_eq("t1_we_data", q_at(we_data_q, i), 32'h11 * (i + 1));
         check_eq("t1_miso_zero", {24'h0, rx_buf[i+1]}, 32'h0);
      end
      check_eq("t1_miso_cmd", {24'h0, rx_buf[0]}, 32'h0);
      check_eq("t1_re_cnt", re_addr_q.size(), 32'd0);

      // 2: read burst, model returns addr+0x40
      clear_logs();
      tx_buf[0] = 8'h90; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
      run_frame(3, 1);
      check_eq("t2_rd0", {24'h0, rx_buf[1]}, 32'h50);
      check_eq("t2_rd1", {24'h0, rx_buf[2]}, 32'h51);
      check_eq("t2_re_cnt", re_addr_q.size(), 32'd3);
      for (int i = 0; i < 3; i++) check_eq("t2_re_addr", q_at(re_addr_q, i), 32'h10 + i);
      check_eq("t2_we_cnt", we_addr_q.size(), 32'd0);

      // 3: address wrap, and hold with AUTO_INC=0
      clear_logs();
      tx_buf[0] = 8'h7F; tx_buf[1] = 8'hA5; tx_buf[2] = 8'h5A;
      run_frame(3, 1);
      check_eq("t3_we_cnt", we_addr_q.size(), 32'd2);
      check_eq("t3_we_a0", q_at(we_addr_q, 0), 32'h7F);
      check_eq("t3_we_a1", q_at(we_addr_q, 1), 32'h00);
      check_eq("t3_we_d1", q_at(we_data_q, 1), 32'h5A);
      check_eq("t3_ni_cnt", ni_addr_q.size(), 32'd2);
      check_eq("t3_ni_a0", q_at(ni_addr_q, 0), 32'h7F);
      check_eq("t3_ni_a1", q_at(ni_addr_q, 1), 32'h7F);

      // 4: abort after 5 data bits
      clear_logs();
      spi_csn = 1'b0;
      sclk_half(); sclk_half();
      xfer_bits(8'h20, 8, r);
      xfer_bits(8'hFF, 5, r);
      spi_csn = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("t4_busy_drop", {31'h0, busy}, 32'h0);
      repeat (6) @(negedge clk);
      check_eq("t4_fe_cycles", fe_cycles, 32'd1);
      check_eq("t4_we_cnt", we_addr_q.size(), 32'd0);

      // 5: reset mid-read, then a clean frame
      clear_logs();
      spi_csn = 1'b0;
      sclk_half(); sclk_half();
      xfer_bits(8'h85, 3, r);
      reset = 1'b1;
      spi_csn = 1'b1;
      @(negedge clk);
      check_eq("t5_busy", {31'h0, busy}, 32'h0);
      check_eq("t5_miso_oe", {30'h0, spi_miso, spi_miso_oe}, 32'h0);
      check_eq("t5_bus", {17'h0, bus.reg_addr, bus.reg_wdata}, 32'h0);
      check_eq("t5_strobes", {29'h0, bus.reg_we, bus.reg_re, frame_err}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("t5_no_strobe", we_addr_q.size() + re_addr_q.size() + fe_cycles, 32'd0);
      tx_buf[0] = 8'h81; tx_buf[1] = 8'h00;
      run_frame(2, 1);
      check_eq("t5_rd", {24'h0, rx_buf[1]}, 32'h41);
      check_eq("t5_re_a0", q_at(re_addr_q, 0), 32'h01);
      check_eq("t5_re_a1", q_at(re_addr_q, 1), 32'h02);

      // 6: random write/readback bursts with random csn-to-first-edge delay
      clear_logs();
      model_mode = 1'b1;
      for (int k = 0; k < 32; k++) begin
         a = 7'($urandom_range(0, 127));
         tx_buf[0] = {1'b0, a};
         for (int i = 0; i < 8; i++) begin
            tx_buf[i+1] = 8'($urandom_range(0, 255));
            exp_mem[7'(a + 7'(i))] = tx_buf[i+1];
         end
         pre = $urandom_range(1, 4);
         run_frame(9, pre);
         tx_buf[0] = {1'b1, a};
         for (int i = 0; i < 8; i++) tx_buf[i+1] = 8'h00;
         pre = $urandom_range(1, 4);
         run_frame(9, pre);
         for (int i = 0; i < 8; i++)
            check_eq("t6_readback", {24'h0, rx_buf[i+1]}, {24'h0, exp_mem[7'(a + 7'(i))]});
      end
      check_eq("t6_fe_none", fe_cycles, 32'd0);
      check_eq("we_re_overlap", both_cnt, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
